// File: rtl/mame_key_encoder.sv
// Scans 16 arcade key inputs and emits PS/2-style key events, one per scan slot, with a fixed idle gap after each event.
// Optional per-key debounce is enabled by defining MAME_KEYENC_DEBOUNCE_EN.
module mame_key_encoder #(
  parameter int EVENT_GAP       = 4,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] keys,
  output logic [10:0] ps2_key,
  output logic        event_strobe,
  output logic        busy
);

  typedef enum logic {S_SCAN, S_GAP} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_idx;
  logic [7:0]  r_gap_cnt;
  logic [15:0] r_reported;
  logic [15:0] w_filt;
  logic        w_hit;
  logic        w_emit;

  if (EVENT_GAP < 1 || EVENT_GAP > 255 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
    $error("mame_key_encoder: EVENT_GAP must be 1..255 and DEBOUNCE_CYCLES >= 1");
  end

  function automatic logic [8:0] key_code(input logic [3:0] idx);
    case (idx)
      4'd0:    key_code = 9'h016;
      4'd1:    key_code = 9'h01E;
      4'd2:    key_code = 9'h02E;
      4'd3:    key_code = 9'h036;
      4'd4:    key_code = 9'h175;
      4'd5:    key_code = 9'h172;
      4'd6:    key_code = 9'h16B;
      4'd7:    key_code = 9'h174;
      4'd8:    key_code = 9'h014;
      4'd9:    key_code = 9'h011;
      4'd10:   key_code = 9'h029;
      4'd11:   key_code = 9'h012;
      4'd12:   key_code = 9'h04D;
      4'd13:   key_code = 9'h006;
      4'd14:   key_code = 9'h046;
      default: key_code = 9'h004;
    endcase
  endfunction

`ifdef MAME_KEYENC_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  logic [DB_W-1:0] r_db_cnt [16];
  logic [15:0]     r_filt;

  // Counter tracks consecutive cycles the raw level disagrees with the filtered level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_filt <= '0;
      for (int i = 0; i < 16; i++) r_db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (keys[i] == r_filt[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          r_filt[i]   <= keys[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_filt = r_filt;
`else
  assign w_filt = keys;
`endif

  assign w_hit = (w_filt[r_idx] != r_reported[r_idx]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_SCAN;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_SCAN:  if (w_hit) w_next_state = S_GAP;
      S_GAP:   if (r_gap_cnt == 8'd0) w_next_state = S_SCAN;
      default: w_next_state = S_SCAN;
    endcase
  end

  always_comb begin
    busy   = (r_state == S_GAP);
    w_emit = (r_state == S_SCAN) && w_hit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ps2_key      <= '0;
      event_strobe <= 1'b0;
      r_reported   <= '0;
      r_idx        <= '0;
      r_gap_cnt    <= '0;
    end else begin
      event_strobe <= w_emit;
      if (w_emit) begin
        ps2_key           <= {~ps2_key[10], w_filt[r_idx], key_code(r_idx)};
        r_reported[r_idx] <= w_filt[r_idx];
        r_gap_cnt         <= 8'(EVENT_GAP - 1);
      end else if (r_state == S_GAP && r_gap_cnt != 8'd0) begin
        r_gap_cnt <= r_gap_cnt - 8'd1;
      end
      if (r_state == S_SCAN) r_idx <= r_idx + 4'd1;
    end
  end

endmodule

// File: tb/tb_mame_key_encoder.sv
// Self-checking bench for mame_key_encoder (default build, debounce disabled) against an event-level reference model.
module tb_mame_key_encoder;

  localparam int EVENT_GAP = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] keys = '0;
  logic [10:0] ps2_key;
  logic        event_strobe;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [8:0]  codes [16] = '{9'h016, 9'h01E, 9'h02E, 9'h036, 9'h175, 9'h172, 9'h16B, 9'h174,
                              9'h014, 9'h011, 9'h029, 9'h012, 9'h04D, 9'h006, 9'h046, 9'h004};
  logic [15:0] m_rep;
  int          m_idx;
  int          m_gap_left;
  logic [10:0] m_key;
  logic        m_strobe;
  logic        m_busy;

  mame_key_encoder #(.EVENT_GAP(EVENT_GAP), .DEBOUNCE_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .keys(keys),
    .ps2_key(ps2_key), .event_strobe(event_strobe), .busy(busy)
  );

  always #5 clk = ~clk;

  // Advance the model by one clock using the current inputs, then one DUT clock; outputs sampled 1 ns later.
  task automatic tick();
    if (reset) begin
      m_rep = '0; m_idx = 0; m_gap_left = 0; m_key = '0; m_strobe = 1'b0;
    end else begin
      m_strobe = 1'b0;
      if (m_gap_left > 0) begin
        m_gap_left--;
      end else begin
        if (keys[m_idx] != m_rep[m_idx]) begin
          m_rep[m_idx] = keys[m_idx];
          m_key = {~m_key[10], keys[m_idx], codes[m_idx]};
          m_strobe = 1'b1;
          m_gap_left = EVENT_GAP;
        end
        m_idx = (m_idx + 1) % 16;
      end
    end
    m_busy = (m_gap_left > 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    keys = 16'hFFFF;
    reset = 1'b1;
    #3;
    n_checks++;
    if ({ps2_key, event_strobe, busy} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ps2_key=%h strobe=%b busy=%b, want all zero", ps2_key, event_strobe, busy);
    end
    tick();
    tick();
    n_checks++;
    if ({ps2_key, event_strobe, busy} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_held: got ps2_key=%h strobe=%b busy=%b, want all zero", ps2_key, event_strobe, busy);
    end
    keys = '0;
  endtask

  task automatic test_single_press();
    int strobes = 0; int busy_cycles = 0; logic [10:0] got = '0;
    do_reset();
    keys = 16'h0010;
    for (int i = 0; i < 40; i++) begin
      tick();
      n_checks++;
      if ({ps2_key, event_strobe, busy} !== {m_key, m_strobe, m_busy}) begin
        n_fail++;
        $display("FAIL press_cycle%0d: got %h/%b/%b want %h/%b/%b", i, ps2_key, event_strobe, busy, m_key, m_strobe, m_busy);
      end
      if (event_strobe) begin strobes++; got = ps2_key; end
      if (busy) busy_cycles++;
    end
    n_checks++;
    if (strobes != 1 || got !== 11'h775 || busy_cycles != 4) begin
      n_fail++;
      $display("FAIL press_up: got %0d strobes key=%h busy=%0d, want 1 strobe key=775 busy=4", strobes, got, busy_cycles);
    end
  endtask

  task automatic test_release();
    int strobes = 0; logic [10:0] got = '0;
    keys = 16'h0000;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (event_strobe) begin strobes++; got = ps2_key; end
    end
    n_checks++;
    if (strobes != 1 || got !== 11'h175) begin
      n_fail++;
      $display("FAIL release_up: got %0d strobes key=%h, want 1 strobe key=175", strobes, got);
    end
  endtask

  task automatic test_two_keys();
    int t[$]; logic [10:0] k[$];
    do_reset();
    keys = 16'h0003;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (event_strobe) begin t.push_back(i); k.push_back(ps2_key); end
    end
    n_checks++;
    if (t.size() != 2) begin
      n_fail++;
      $display("FAIL two_keys_count: got %0d events, want 2", t.size());
    end else begin
      n_checks++;
      if (k[0][9:0] !== 10'h216 || k[1][9:0] !== 10'h21E || t[1] - t[0] != EVENT_GAP + 1) begin
        n_fail++;
        $display("FAIL two_keys_order: got %h,%h spacing %0d, want x216,x21E spacing %0d",
                 k[0], k[1], t[1] - t[0], EVENT_GAP + 1);
      end
    end
  endtask

  task automatic test_glitch();
    int strobes = 0;
    do_reset();
    keys = 16'h1000;
    tick();
    keys = 16'h0000;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (event_strobe) strobes++;
    end
    n_checks++;
    if (strobes != 0) begin
      n_fail++;
      $display("FAIL glitch_pause: got %0d events, want 0", strobes);
    end
  endtask

  task automatic test_reset_mid_gap();
    int waited = 0; logic seen = 1'b0;
    do_reset();
    keys = 16'h8000;
    for (int i = 0; i < 16; i++) tick();
    tick();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midgap_busy: got busy=%b, want 1", busy);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({ps2_key, event_strobe, busy} !== 13'd0) begin
      n_fail++;
      $display("FAIL midgap_reset: got ps2_key=%h strobe=%b busy=%b, want all zero", ps2_key, event_strobe, busy);
    end
    tick();
    reset = 1'b0;
    while (!seen && waited < 16) begin
      tick();
      waited++;
      if (event_strobe) seen = 1'b1;
    end
    n_checks++;
    if (!seen || ps2_key !== 11'h604) begin
      n_fail++;
      $display("FAIL midgap_repress: got seen=%b key=%h after %0d cycles, want key=604 within 16", seen, ps2_key, waited);
    end
  endtask

  task automatic test_random();
    int hold = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        if ($urandom_range(3) == 0) keys = 16'($urandom);
        else keys = keys ^ (16'd1 << $urandom_range(15));
        hold = $urandom_range(40, 1);
      end
      hold--;
      tick();
      n_checks++;
      if ({ps2_key, event_strobe, busy} !== {m_key, m_strobe, m_busy}) begin
        n_fail++;
        $display("FAIL random_cycle%0d: got %h/%b/%b want %h/%b/%b", i, ps2_key, event_strobe, busy, m_key, m_strobe, m_busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_release();
    test_two_keys();
    test_glitch();
    test_reset_mid_gap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mame_key_encoder.md
MAME_KEY_ENCODER -- requirements
Module: mame_key_encoder

Interface
REQ-001 SHALL provide parameter EVENT_GAP, default 4, meaning idle cycles enforced after each emitted event (legal range 1..255).
REQ-002 SHALL provide parameter DEBOUNCE_CYCLES, default 8, meaning consecutive stable cycles required before a key change is accepted (used only under REQ-021).
REQ-003 SHALL provide port clk  input  1  single clock for all logic.
REQ-004 SHALL provide port reset  input  1  asynchronous active-high reset.
REQ-005 SHALL provide port keys  input  16  live key levels, 1 = held, synchronous to clk.
REQ-006 SHALL provide port ps2_key  output  11  event word: [10] toggle, [9] pressed, [8] extended flag, [7:0] scan code.
REQ-007 SHALL provide port event_strobe  output  1  one-cycle pulse coincident with each new ps2_key value.
REQ-008 SHALL provide port busy  output  1  high while in GAP state.

Function
REQ-009 SHALL map keys index to 9-bit code: 0 start1 016, 1 start2 01E, 2 coin1 02E, 3 coin2 036, 4 up 175, 5 down 172, 6 left 16B, 7 right 174, 8 btn1 014, 9 btn2 011, 10 btn3 029, 11 btn4 012, 12 pause 04D, 13 test 006, 14 service 046, 15 reset 004.
REQ-010 SHALL hold a 16-bit reported vector, the last key state sent per index.
REQ-011 SHALL implement two states: SCAN and GAP.
REQ-012 SCAN: each cycle examine index idx (4-bit); on mismatch between filtered key and reported[idx], on that edge load ps2_key[8:0]=code(idx), ps2_key[9]=filtered key, invert ps2_key[10], set reported[idx], pulse event_strobe, enter GAP with gap counter EVENT_GAP-1.
REQ-013 SCAN with no mismatch: ps2_key unchanged, event_strobe low.
REQ-014 idx SHALL increment by one after every SCAN cycle (match or mismatch), wrapping 15 -> 0; idx frozen during GAP.
REQ-015 GAP: counter decrements each cycle; counter at 0 -> SCAN next cycle; total GAP residency exactly EVENT_GAP cycles.
REQ-016 At most one event per SCAN cycle; simultaneous changes emitted in scan order starting from current idx.
REQ-017 Key that changes and reverts before its index is scanned SHALL produce no event.
REQ-018 Key changes during GAP SHALL be retained against reported and emitted on a later scan.
REQ-019 Worst-case latency from stable change to event: 16 x (EVENT_GAP+1) cycles (plus debounce when enabled).

Reset
REQ-020 On reset assertion (any time, including mid-GAP): ps2_key=0, event_strobe=0, busy=0, reported=0, idx=0, gap counter=0, debounce state cleared, state SCAN; keys held through reset are reported as press events after release.

Configuration
REQ-021 Macro MAME_KEYENC_DEBOUNCE_EN defined: each key passes a per-key filter; filtered level changes only after raw input differs from it for DEBOUNCE_CYCLES consecutive cycles; filtered levels reset to 0.
REQ-022 Macro undefined: filtered key equals keys directly; no debounce counters synthesized; DEBOUNCE_CYCLES ignored.

Verification
REQ-023 After reset, keys=0x0010 held -> one event ps2_key=11'h775 (toggle 1, pressed, up), event_strobe one cycle, busy high 4 cycles.
REQ-024 keys 0x0010 -> 0x0000 after REQ-023 -> ps2_key=11'h175, toggle back to 0.
REQ-025 keys=0x0003 applied with idx=0 -> events 016 pressed then 01E pressed, spaced exactly EVENT_GAP+1 cycles.
REQ-026 keys bit 12 pulsed high 1 cycle while idx=0 -> no event (debounce off); with MAME_KEYENC_DEBOUNCE_EN, bit 12 high 7 cycles -> no event, 8 cycles -> one event 04D pressed.
REQ-027 reset asserted mid-GAP with keys=0x8000 -> outputs zero immediately; after release event 004 pressed emitted within 16 cycles.
